// File: rtl/flash_sample_reader.sv
// flash_sample_reader: delivers one signed 16-bit audio sample per start pulse.
// Samples are packed two per 32-bit Avalon-MM flash word. The last fetched word
// is kept in a one-word buffer, so the second half of a word costs no bus read.
// The sample position steps forward or backward after each delivery and wraps
// at the song bounds.
module flash_sample_reader #(
   parameter int                ADDR_W   = 23,
   parameter logic [ADDR_W-1:0] MAX_ADDR = 'h7FFFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_read_flash,
   input  logic              dir,
   input  logic              restart,
   output logic              flash_mem_read,
   output logic [ADDR_W-1:0] flash_mem_address,
   output logic [3:0]        flash_mem_byteenable,
   input  logic              flash_mem_waitrequest,
   input  logic [31:0]       flash_mem_readdata,
   input  logic              flash_mem_readdatavalid,
   output logic [15:0]       audio_sample,
   output logic              flash_read_finished
);

   localparam int PW = ADDR_W + 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, OUT} state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       pos_q, pos_d;
   logic                dir_q, dir_d;
   logic [31:0]         buf_data_q, buf_data_d;
   logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
   logic                buf_vld_q, buf_vld_d;
   logic                rst_pend_q, rst_pend_d;
   logic                rst_dir_q, rst_dir_d;
   logic                read_q, read_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [15:0]         sample_q, sample_d;
   logic                fin_q, fin_d;
   logic [PW-1:0]       eff_pos;
   logic                eff_vld;

   // Next position after a delivery; wraps between {0,0} and {MAX_ADDR,1}.
   function automatic logic [PW-1:0] step_pos(input logic [PW-1:0] p, input logic fwd);
      if (fwd) return (p == {MAX_ADDR, 1'b1}) ? '0 : p + 1'b1;
      else     return (p == '0) ? {MAX_ADDR, 1'b1} : p - 1'b1;
   endfunction

   // Song start for the given direction.
   function automatic logic [PW-1:0] rewind_pos(input logic fwd);
      return fwd ? '0 : {MAX_ADDR, 1'b1};
   endfunction

   // Half 0 is the low 16 bits of the word, half 1 the high 16 bits.
   function automatic logic [15:0] select_half(input logic [31:0] w, input logic h);
      return h ? w[31:16] : w[15:0];
   endfunction

   // Next-state logic for the request FSM, position and sample buffer.
   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      dir_d      = dir_q;
      buf_data_d = buf_data_q;
      buf_addr_d = buf_addr_q;
      buf_vld_d  = buf_vld_q;
      rst_pend_d = rst_pend_q;
      rst_dir_d  = rst_dir_q;
      read_d     = read_q;
      addr_d     = addr_q;
      sample_d   = sample_q;
      fin_d      = 1'b0;
      eff_pos    = pos_q;
      eff_vld    = buf_vld_q;
      unique case (state_q)
         IDLE: begin
            // A restart in the same cycle as start is applied before the lookup.
            eff_pos   = restart ? rewind_pos(dir) : pos_q;
            eff_vld   = restart ? 1'b0 : buf_vld_q;
            pos_d     = eff_pos;
            buf_vld_d = eff_vld;
            if (start_read_flash) begin
               dir_d = dir;
               if (eff_vld && (buf_addr_q == eff_pos[PW-1:1])) begin
                  state_d  = OUT;
                  sample_d = select_half(buf_data_q, eff_pos[0]);
                  fin_d    = 1'b1;
               end else begin
                  state_d = REQ;
                  read_d  = 1'b1;
                  addr_d  = eff_pos[PW-1:1];
               end
            end
         end
         REQ: begin
            if (restart) begin
               rst_pend_d = 1'b1;
               rst_dir_d  = dir;
            end
            if (!flash_mem_waitrequest) begin
               state_d = WAIT_DATA;
               read_d  = 1'b0;
            end
         end
         WAIT_DATA: begin
            if (restart) begin
               rst_pend_d = 1'b1;
               rst_dir_d  = dir;
            end
            if (flash_mem_readdatavalid) begin
               buf_data_d = flash_mem_readdata;
               buf_addr_d = pos_q[PW-1:1];
               buf_vld_d  = 1'b1;
               sample_d   = select_half(flash_mem_readdata, pos_q[0]);
               fin_d      = 1'b1;
               state_d    = OUT;
            end
         end
         OUT: begin
            // A restart seen during the transaction overrides the normal step.
            state_d = IDLE;
            if (restart || rst_pend_q) begin
               pos_d      = rewind_pos(restart ? dir : rst_dir_q);
               buf_vld_d  = 1'b0;
               rst_pend_d = 1'b0;
            end else begin
               pos_d = step_pos(pos_q, dir_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pos_q      <= '0;
         dir_q      <= 1'b0;
         buf_data_q <= '0;
         buf_addr_q <= '0;
         buf_vld_q  <= 1'b0;
         rst_pend_q <= 1'b0;
         rst_dir_q  <= 1'b0;
         read_q     <= 1'b0;
         addr_q     <= '0;
         sample_q   <= '0;
         fin_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         dir_q      <= dir_d;
         buf_data_q <= buf_data_d;
         buf_addr_q <= buf_addr_d;
         buf_vld_q  <= buf_vld_d;
         rst_pend_q <= rst_pend_d;
         rst_dir_q  <= rst_dir_d;
         read_q     <= read_d;
         addr_q     <= addr_d;
         sample_q   <= sample_d;
         fin_q      <= fin_d;
      end
   end

   assign flash_mem_read       = read_q;
   assign flash_mem_address    = addr_q;
   assign flash_mem_byteenable = 4'hF;
   assign audio_sample         = sample_q;
   assign flash_read_finished  = fin_q;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Bench for flash_sample_reader: directed start/restart sequences against a
// transaction-level model (linear sample index, one-word buffer, expected
// sample and read-address queues) and an Avalon flash responder.
module tb_flash_sample_reader;

   localparam int          ADDR_W = 23;
   localparam logic [22:0] MAX_A  = 23'h7FFFF;
   localparam int          TOTAL  = 2 * (int'(MAX_A) + 1);

   logic        clk;
   logic        reset;
   logic        start_read_flash;
   logic        dir;
   logic        restart;
   logic        flash_mem_read;
   logic [22:0] flash_mem_address;
   logic [3:0]  flash_mem_byteenable;
   logic        flash_mem_waitrequest;
   logic [31:0] flash_mem_readdata;
   logic        flash_mem_readdatavalid;
   logic [15:0] audio_sample;
   logic        flash_read_finished;

   flash_sample_reader #(.ADDR_W(ADDR_W), .MAX_ADDR(MAX_A)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .start_read_flash        (start_read_flash),
      .dir                     (dir),
      .restart                 (restart),
      .flash_mem_read          (flash_mem_read),
      .flash_mem_address       (flash_mem_address),
      .flash_mem_byteenable    (flash_mem_byteenable),
      .flash_mem_waitrequest   (flash_mem_waitrequest),
      .flash_mem_readdata      (flash_mem_readdata),
      .flash_mem_readdatavalid (flash_mem_readdatavalid),
      .audio_sample            (audio_sample),
      .flash_read_finished     (flash_read_finished)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
   endtask

   // Flash contents
   function automatic logic [31:0] mem_word(input logic [22:0] a);
      if (a == 23'd0)             return 32'hBBBB_AAAA;
      else if (a == 23'd1)        return 32'hDDDD_CCCC;
      else if (a == 23'd7)        return 32'h7777_6666;
      else if (a == MAX_A)        return 32'h2222_1111;
      else if (a == MAX_A - 23'd1) return 32'h4444_3333;
      else                        return {~a[15:0], a[15:0]};
   endfunction

   // Model: sample index = 2*word + half, buffered word, expectation queues
   int          m_idx;
   bit          m_bvld;
   logic [22:0] m_baddr;
   logic [15:0] exp_q[$];
   logic [22:0] exp_rd_q[$];
   logic [15:0] last_sample;
   int          n_fin   = 0;
   int          n_reads = 0;
   logic [22:0] last_rd_addr;
   bit          in_reset;

   task automatic model_start(input bit d);
      logic [22:0] word;
      logic [31:0] w;
      word = 23'(m_idx / 2);
      if (!m_bvld || m_baddr != word) exp_rd_q.push_back(word);
      m_bvld  = 1'b1;
      m_baddr = word;
      w = mem_word(word);
      exp_q.push_back((m_idx % 2) == 1 ? w[31:16] : w[15:0]);
      m_idx = d ? (m_idx + 1) % TOTAL : (m_idx + TOTAL - 1) % TOTAL;
   endtask

   task automatic model_restart(input bit d);
      m_idx  = d ? 0 : TOTAL - 1;
      m_bvld = 1'b0;
   endtask

   // Compare process: every delivery against the model, otherwise hold value
   always @(negedge clk) begin
      if (!in_reset) begin
         if (flash_read_finished) begin
            n_fin++;
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_finished: actual sample=%h required=no delivery", audio_sample);
            end else begin
               last_sample = exp_q.pop_front();
               check("sample", {16'h0, audio_sample}, {16'h0, last_sample});
            end
         end else begin
            check("sample_hold", {16'h0, audio_sample}, {16'h0, last_sample});
         end
      end
   end

   // Avalon flash responder with programmable waitrequest length
   int          wait_n = 0;
   int          wcnt = 0;
   bit          prev_wr = 1'b0;
   bit          pend_rdv = 1'b0;
   logic [31:0] pend_data;
   logic [22:0] held_addr;

   always @(negedge clk) begin
      flash_mem_readdatavalid = pend_rdv;
      flash_mem_readdata      = pend_rdv ? pend_data : 32'h0;
      pend_rdv = 1'b0;
      if (prev_wr && !in_reset) begin
         check("stall_read", {31'h0, flash_mem_read}, 32'h1);
         check("stall_addr", {9'h0, flash_mem_address}, {9'h0, held_addr});
      end
      if (flash_mem_read && !reset) begin
         if (wcnt < wait_n) begin
            flash_mem_waitrequest = 1'b1;
            held_addr = flash_mem_address;
            wcnt++;
         end else begin
            flash_mem_waitrequest = 1'b0;
            wcnt = 0;
            n_reads++;
            last_rd_addr = flash_mem_address;
            if (exp_rd_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_read: actual addr=%h required=no read", flash_mem_address);
            end else begin
               check("read_addr", {9'h0, flash_mem_address}, {9'h0, exp_rd_q.pop_front()});
            end
            pend_rdv  = 1'b1;
            pend_data = mem_word(flash_mem_address);
         end
      end else begin
         flash_mem_waitrequest = 1'b0;
         wcnt = 0;
      end
      prev_wr = flash_mem_waitrequest;
   end

   // Wait (bounded) for finished; lat counts negedges waited from the call
   task automatic wait_fin(output int lat);
      lat = 0;
      while (!flash_read_finished && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      if (!flash_read_finished) begin
         n_checks++;
         $display("FAIL finished_timeout: actual=no pulse required=pulse within 60 cycles");
      end
   endtask

   // One start pulse; optionally pin latency and sample to hand-computed values
   task automatic do_start(input bit d, input bit pin, input int exp_lat, input logic [15:0] exp_s);
      int l;
      @(negedge clk);
      dir = d;
      start_read_flash = 1'b1;
      model_start(d);
      @(negedge clk);
      start_read_flash = 1'b0;
      wait_fin(l);
      if (pin && flash_read_finished) begin
         check("latency", 32'(l + 1), 32'(exp_lat));
         check("lit_sample", {16'h0, audio_sample}, {16'h0, exp_s});
      end
   endtask

   task automatic pulse_restart(input bit d);
      @(negedge clk);
      dir = d;
      restart = 1'b1;
      model_restart(d);
      @(negedge clk);
      restart = 1'b0;
   endtask

   initial begin
      int r0, f0, l;
      reset = 1'b1;
      in_reset = 1'b1;
      start_read_flash = 1'b0;
      restart = 1'b0;
      dir = 1'b1;
      flash_mem_waitrequest = 1'b0;
      flash_mem_readdatavalid = 1'b0;
      flash_mem_readdata = 32'h0;
      m_idx = 0;
      m_bvld = 1'b0;
      m_baddr = '0;
      last_sample = 16'h0;
      last_rd_addr = '0;
      repeat (3) @(negedge clk);
      check("rst_read", {31'h0, flash_mem_read}, 32'h0);
      check("rst_addr", {9'h0, flash_mem_address}, 32'h0);
      check("rst_sample", {16'h0, audio_sample}, 32'h0);
      check("rst_finished", {31'h0, flash_read_finished}, 32'h0);
      check("byteenable", {28'h0, flash_mem_byteenable}, 32'hF);
      reset = 1'b0;
      @(posedge clk);
      #1 in_reset = 1'b0;

      // Forward through words 0 and 1: two reads for three samples
      r0 = n_reads;
      do_start(1'b1, 1'b1, 3, 16'hAAAA);
      do_start(1'b1, 1'b1, 1, 16'hBBBB);
      do_start(1'b1, 1'b1, 3, 16'hCCCC);
      check("reads_3_starts", 32'(n_reads - r0), 32'd2);

      // Backward from song end
      pulse_restart(1'b0);
      do_start(1'b0, 1'b1, 3, 16'h2222);
      do_start(1'b0, 1'b1, 1, 16'h1111);
      do_start(1'b0, 1'b1, 3, 16'h4444);
      check("bwd_addr", {9'h0, last_rd_addr}, {9'h0, MAX_A - 23'd1});

      // Forward wrap from {MAX,1} to {0,0}
      pulse_restart(1'b0);
      do_start(1'b1, 1'b1, 3, 16'h2222);
      do_start(1'b1, 1'b1, 3, 16'hAAAA);
      check("wrap_addr", {9'h0, last_rd_addr}, 32'h0);

      // Five stall cycles
      pulse_restart(1'b1);
      wait_n = 5;
      f0 = n_fin;
      do_start(1'b1, 1'b1, 8, 16'hAAAA);
      wait_n = 0;
      repeat (3) @(negedge clk);
      check("stall_fin_once", 32'(n_fin - f0), 32'd1);

      // Walk to word 7, then restart during WAIT_DATA
      pulse_restart(1'b1);
      for (int i = 0; i < 14; i++) do_start(1'b1, 1'b0, 0, 16'h0);
      @(negedge clk);
      dir = 1'b1;
      start_read_flash = 1'b1;
      model_start(1'b1);
      @(negedge clk);
      start_read_flash = 1'b0;
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      wait_fin(l);
      check("rs_latency", 32'(l + 3), 32'd3);
      check("rs_sample", {16'h0, audio_sample}, 32'h6666);
      model_restart(1'b1);
      do_start(1'b1, 1'b1, 3, 16'hAAAA);
      check("rs_next_addr", {9'h0, last_rd_addr}, 32'h0);

      // start during REQ is ignored
      pulse_restart(1'b1);
      wait_n = 2;
      f0 = n_fin;
      r0 = n_reads;
      @(negedge clk);
      start_read_flash = 1'b1;
      model_start(1'b1);
      @(negedge clk);
      start_read_flash = 1'b0;
      @(negedge clk);
      start_read_flash = 1'b1;
      @(negedge clk);
      start_read_flash = 1'b0;
      wait_fin(l);
      check("ign_latency", 32'(l + 3), 32'd5);
      repeat (4) @(negedge clk);
      check("ign_fin_once", 32'(n_fin - f0), 32'd1);
      check("ign_reads", 32'(n_reads - r0), 32'd1);
      wait_n = 0;

      // reset during WAIT_DATA
      pulse_restart(1'b1);
      @(negedge clk);
      start_read_flash = 1'b1;
      model_start(1'b1);
      @(negedge clk);
      start_read_flash = 1'b0;
      @(posedge clk);
      #1;
      in_reset = 1'b1;
      reset = 1'b1;
      exp_q.delete();
      exp_rd_q.delete();
      m_idx = 0;
      m_bvld = 1'b0;
      last_sample = 16'h0;
      @(negedge clk);
      @(negedge clk);
      check("mid_rst_sample", {16'h0, audio_sample}, 32'h0);
      check("mid_rst_fin", {31'h0, flash_read_finished}, 32'h0);
      check("mid_rst_read", {31'h0, flash_mem_read}, 32'h0);
      @(negedge clk);
      check("mid_rst_fin2", {31'h0, flash_read_finished}, 32'h0);
      reset = 1'b0;
      @(posedge clk);
      #1 in_reset = 1'b0;
      do_start(1'b1, 1'b1, 3, 16'hAAAA);

      repeat (3) @(negedge clk);
      check("model_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
